// File: rtl/lc_pkg.sv
// Shared types and default widths for the level-crossing gate controller.
package lc_pkg;

  localparam int LC_CNT_W = 4;
  localparam int LC_OCC_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    F1,
    F2,
    F3,
    R1,
    R2,
    R3,
    ERR
  } wheel_state_t;

endpackage

// File: rtl/wheel_dir_fsm.sv
// Decodes wheel direction at one sensor point from the a/b assertion order.
module wheel_dir_fsm
  import lc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic fwd_pulse,
  output logic rev_pulse
);

  wheel_state_t state;
  wheel_state_t state_nxt;
  logic         fwd_nxt;
  logic         rev_nxt;
  logic [1:0]   ab;

  assign ab = {a, b};

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fwd_pulse <= 1'b0;
      rev_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      fwd_pulse <= fwd_nxt;
      rev_pulse <= rev_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fwd_nxt   = 1'b0;
    rev_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        case (ab)
          2'b10:   state_nxt = F1;
          2'b01:   state_nxt = R1;
          default: state_nxt = IDLE;
        endcase
      end
      F1: begin
        case (ab)
          2'b11:   state_nxt = F2;
          2'b00:   state_nxt = IDLE;
          2'b01:   state_nxt = ERR;
          default: state_nxt = F1;
        endcase
      end
      F2: begin
        case (ab)
          2'b01:   state_nxt = F3;
          2'b10:   state_nxt = F1;
          2'b00:   state_nxt = ERR;
          default: state_nxt = F2;
        endcase
      end
      F3: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            fwd_nxt   = 1'b1;
          end
          2'b11:   state_nxt = F2;
          2'b10:   state_nxt = ERR;
          default: state_nxt = F3;
        endcase
      end
      R1: begin
        case (ab)
          2'b11:   state_nxt = R2;
          2'b00:   state_nxt = IDLE;
          2'b10:   state_nxt = ERR;
          default: state_nxt = R1;
        endcase
      end
      R2: begin
        case (ab)
          2'b10:   state_nxt = R3;
          2'b01:   state_nxt = R1;
          2'b00:   state_nxt = ERR;
          default: state_nxt = R2;
        endcase
      end
      R3: begin
        case (ab)
          2'b00: begin
            state_nxt = IDLE;
            rev_nxt   = 1'b1;
          end
          2'b11:   state_nxt = R2;
          2'b01:   state_nxt = ERR;
          default: state_nxt = R3;
        endcase
      end
      ERR: begin
        // Only a fully clear point re-arms the decoder.
        if (ab == 2'b00) state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/level_crossing_ctrl.sv
// Gate controller: wheel counters, section occupancy and barrier output.
// Define SENSOR_SYNC_EN to add 2-FF synchronizers on the four sensors.
module level_crossing_ctrl
  import lc_pkg::*;
#(
  parameter int CNT_W = LC_CNT_W,
  parameter int OCC_W = LC_OCC_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             a1,
  input  logic             b1,
  input  logic             a2,
  input  logic             b2,
  output logic             a2b_1,
  output logic             a2b_2,
  output logic             b2a_1,
  output logic             b2a_2,
  output logic [CNT_W-1:0] Count_a2b_1,
  output logic [CNT_W-1:0] Count_a2b_2,
  output logic [CNT_W-1:0] Count_b2a_1,
  output logic [CNT_W-1:0] Count_b2a_2,
  output logic             gate_open
);

  localparam logic [OCC_W:0] OCC_MAX = {1'b0, {OCC_W{1'b1}}};

  logic [3:0] sens;

`ifdef SENSOR_SYNC_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= {a1, b1, a2, b2};
      sync_q2 <= sync_q1;
    end
  end

  assign sens = sync_q2;
`else
  assign sens = {a1, b1, a2, b2};
`endif

  wheel_dir_fsm u_pt1 (
    .clk       (Clk),
    .reset     (Reset),
    .a         (sens[3]),
    .b         (sens[2]),
    .fwd_pulse (a2b_1),
    .rev_pulse (b2a_1)
  );

  wheel_dir_fsm u_pt2 (
    .clk       (Clk),
    .reset     (Reset),
    .a         (sens[1]),
    .b         (sens[0]),
    .fwd_pulse (a2b_2),
    .rev_pulse (b2a_2)
  );

  logic [3:0]       pulse;
  logic [CNT_W-1:0] cnt_q [4];

  assign pulse = {a2b_1, a2b_2, b2a_1, b2a_2};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        cnt_q[i] <= cnt_q[i] + {{(CNT_W-1){1'b0}}, pulse[3-i]};
    end
  end

  // Counts are shown already incremented in the pulse cycle.
  assign Count_a2b_1 = cnt_q[0] + {{(CNT_W-1){1'b0}}, pulse[3]};
  assign Count_a2b_2 = cnt_q[1] + {{(CNT_W-1){1'b0}}, pulse[2]};
  assign Count_b2a_1 = cnt_q[2] + {{(CNT_W-1){1'b0}}, pulse[1]};
  assign Count_b2a_2 = cnt_q[3] + {{(CNT_W-1){1'b0}}, pulse[0]};

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_nxt;
  logic [1:0]       n_in;
  logic [1:0]       n_out;
  logic [OCC_W:0]   occ_up;
  logic [OCC_W:0]   out_ext;
  logic [OCC_W:0]   occ_dn;

  assign n_in    = {1'b0, a2b_1} + {1'b0, b2a_2};
  assign n_out   = {1'b0, a2b_2} + {1'b0, b2a_1};
  assign occ_up  = {1'b0, occ_q} + {{(OCC_W-1){1'b0}}, n_in};
  assign out_ext = {{(OCC_W-1){1'b0}}, n_out};
  assign occ_dn  = occ_up - out_ext;

  always_comb begin
    occ_nxt = occ_q;
    if (occ_up < out_ext) begin
      occ_nxt = '0;
    end else if (occ_dn > OCC_MAX) begin
      occ_nxt = OCC_MAX[OCC_W-1:0];
    end else begin
      occ_nxt = occ_dn[OCC_W-1:0];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      occ_q     <= '0;
      gate_open <= 1'b1;
    end else begin
      occ_q     <= occ_nxt;
      gate_open <= (occ_nxt == '0);
    end
  end

endmodule

// File: tb/tb_level_crossing_ctrl.sv
// Directed table-driven bench for level_crossing_ctrl (default build).
module tb_level_crossing_ctrl;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       a1, b1, a2, b2;
  logic       a2b_1, a2b_2, b2a_1, b2a_2;
  logic [3:0] Count_a2b_1, Count_a2b_2, Count_b2a_1, Count_b2a_2;
  logic       gate_open;

  level_crossing_ctrl dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .a1          (a1),
    .b1          (b1),
    .a2          (a2),
    .b2          (b2),
    .a2b_1       (a2b_1),
    .a2b_2       (a2b_2),
    .b2a_1       (b2a_1),
    .b2a_2       (b2a_2),
    .Count_a2b_1 (Count_a2b_1),
    .Count_a2b_2 (Count_a2b_2),
    .Count_b2a_1 (Count_b2a_1),
    .Count_b2a_2 (Count_b2a_2),
    .gate_open   (gate_open)
  );

  always #5 Clk = ~Clk;

  // sens = {a1,b1,a2,b2}; pls/cnts ordered a2b_1,a2b_2,b2a_1,b2a_2
  typedef struct {
    logic [3:0]  sens;
    logic [3:0]  pls;
    logic [15:0] cnts;
    logic        gate;
  } vec_t;

  vec_t       q[$];
  logic [3:0] m_cnt [4];
  int         m_occ;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic logic [1:0] pat(input int d, input int k);
    if (d == 1) begin
      case (k)
        0: return 2'b10;
        1: return 2'b11;
        2: return 2'b01;
        default: return 2'b00;
      endcase
    end else if (d == 2) begin
      case (k)
        0: return 2'b01;
        1: return 2'b11;
        2: return 2'b10;
        default: return 2'b00;
      endcase
    end
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_cnt[i] = 4'd0;
    m_occ = 0;
  endtask

  task automatic push_step(input logic [3:0] s, input logic [3:0] p);
    vec_t v;
    v.sens = s;
    v.pls  = p;
    v.gate = (m_occ == 0);
    for (int i = 0; i < 4; i++)
      if (p[3-i]) m_cnt[i] = m_cnt[i] + 4'd1;
    v.cnts = {m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]};
    m_occ = m_occ + int'(p[3]) + int'(p[0]) - int'(p[2]) - int'(p[1]);
    if (m_occ < 0) m_occ = 0;
    if (m_occ > 255) m_occ = 255;
    q.push_back(v);
  endtask

  // d: 0 idle, 1 A->B, 2 B->A; pulse shows on the closing 00 step
  task automatic push_wheel(input int d1, input int d2);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) begin
      p = 4'b0000;
      if (k == 3) p = {d1 == 1, d2 == 1, d1 == 2, d2 == 2};
      push_step({pat(d1, k), pat(d2, k)}, p);
    end
  endtask

  task automatic run_queue(input string tag);
    logic [20:0] act;
    logic [20:0] exp;
    for (int i = 0; i < q.size(); i++) begin
      {a1, b1, a2, b2} = q[i].sens;
      @(posedge Clk);
      #1;
      act = {a2b_1, a2b_2, b2a_1, b2a_2, Count_a2b_1, Count_a2b_2,
             Count_b2a_1, Count_b2a_2, gate_open};
      exp = {q[i].pls, q[i].cnts, q[i].gate};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL %s step %0d: got %h want %h", tag, i, act, exp);
      end
    end
    q.delete();
  endtask

  task automatic do_reset(input string tag);
    logic [20:0] act;
    Reset = 1'b1;
    {a1, b1, a2, b2} = 4'b0000;
    repeat (2) @(posedge Clk);
    #1;
    act = {a2b_1, a2b_2, b2a_1, b2a_2, Count_a2b_1, Count_a2b_2,
           Count_b2a_1, Count_b2a_2, gate_open};
    n_cmp++;
    if (act !== 21'h000001) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, 21'h000001);
    end
    Reset = 1'b0;
    model_clear();
  endtask

  initial begin
    Reset = 1'b1;
    {a1, b1, a2, b2} = 4'b0000;
    model_clear();

    do_reset("reset_init");

    push_step(4'b0000, 4'b0000);
    for (int w = 0; w < 16; w++) push_wheel(1, 0);
    push_step(4'b0000, 4'b0000);
    run_queue("pt1_a2b_x16");

    for (int w = 0; w < 16; w++) push_wheel(0, 1);
    push_step(4'b0000, 4'b0000);
    run_queue("pt2_a2b_x16");

    do_reset("reset_t4");
    for (int w = 0; w < 16; w++) push_wheel(0, 2);
    for (int w = 0; w < 16; w++) push_wheel(2, 0);
    push_step(4'b0000, 4'b0000);
    run_queue("b2a_both");

    do_reset("reset_t5");
    for (int w = 0; w < 16; w++) push_wheel(1, 0);
    for (int w = 0; w < 16; w++) push_wheel(2, 0);
    push_step(4'b0000, 4'b0000);
    run_queue("reversal");

    do_reset("reset_t6");
    push_step(4'b0000, 4'b0000);
    push_step(4'b1000, 4'b0000);
    push_step(4'b0000, 4'b0000);
    push_step(4'b1000, 4'b0000);
    push_step(4'b0100, 4'b0000);
    push_step(4'b0000, 4'b0000);
    push_step(4'b1000, 4'b0000);
    push_step(4'b1100, 4'b0000);
    push_step(4'b1000, 4'b0000);
    push_step(4'b1100, 4'b0000);
    push_step(4'b0100, 4'b0000);
    push_step(4'b0000, 4'b1000);
    push_step(4'b0000, 4'b0000);
    run_queue("glitch");

    // ERR must ignore a full forward pattern until 00 is seen
    push_step(4'b1000, 4'b0000);
    push_step(4'b0100, 4'b0000);
    push_step(4'b1000, 4'b0000);
    push_step(4'b1100, 4'b0000);
    push_step(4'b0100, 4'b0000);
    push_step(4'b0000, 4'b0000);
    push_wheel(2, 0);
    push_step(4'b0000, 4'b0000);
    run_queue("err_hold");

    do_reset("reset_t7");
    push_wheel(1, 2);
    push_step(4'b0000, 4'b0000);
    push_wheel(2, 1);
    push_step(4'b0000, 4'b0000);
    push_wheel(0, 1);
    push_step(4'b0000, 4'b0000);
    push_wheel(1, 0);
    push_step(4'b0000, 4'b0000);
    run_queue("simul_clamp0");

    push_step(4'b1010, 4'b0000);
    push_step(4'b1111, 4'b0000);
    run_queue("pre_reset");
    do_reset("reset_mid");
    push_step(4'b0101, 4'b0000);
    push_step(4'b0000, 4'b0000);
    push_step(4'b0000, 4'b0000);
    run_queue("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
